generic_fifo_flex: RTL and testbench
====================================

Name: generic_fifo_flex

Overview:
Parametrised successor to the team's single-clock valid/grant FIFO.
- Supports any depth ≥1, not only powers of two.
- Selectable fall-through (zero-latency) mode.
- Exports fill level and programmable almost-full/almost-empty flags.
- Used as the standard elastic buffer between cluster interconnect stages and peripheral request queues.

Parameters:
- DATA_WIDTH, 32, payload width in bits (≥1)
- DATA_DEPTH, 8, number of entries (≥1, any integer)
- FALL_THROUGH, 0, 1 = data_i bypasses to data_o when empty; 0 = minimum one-cycle latency
- AF_THRESH, DATA_DEPTH-1, almost_full_o asserted when usage ≥ AF_THRESH (0..DATA_DEPTH)
- AE_THRESH, 1, almost_empty_o asserted when usage ≤ AE_THRESH (0..DATA_DEPTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- clear_i  in  1  synchronous flush
- test_mode_i  in  1  forces clock gate transparent (scan)
- data_i  in  DATA_WIDTH  push payload
- valid_i  in  1  push request
- grant_o  out  1  push accepted when valid_i & grant_o
- data_o  out  DATA_WIDTH  pop payload
- valid_o  out  1  pop data valid
- grant_i  in  1  pop accepted when valid_o & grant_i
- usage_o  out  CNT_W  current entry count, CNT_W = $clog2(DATA_DEPTH+1)
- almost_full_o  out  1  usage_o ≥ AF_THRESH
- almost_empty_o  out  1  usage_o ≤ AE_THRESH

Behaviour:
- State: read pointer, write pointer (width max(1,$clog2(DATA_DEPTH))), count register (CNT_W). full = (count == DATA_DEPTH); empty = (count == 0).
- Reset (async): pointers and count = 0.
  - Outputs after reset: grant_o = 1, valid_o = 0, usage_o = 0, almost_full_o = (AF_THRESH == 0), almost_empty_o = 1, data_o = storage entry 0.
  - Storage is not reset.
- grant_o = ~full. It does not depend on grant_i (no combinational pop→push path). When full, pushes are refused even if a pop occurs in the same cycle.
- push = valid_i & grant_o: writes mem[wptr]; wptr advances; wraps DATA_DEPTH-1 → 0.
- pop = valid_o & grant_i: rptr advances with the same wrap rule.
- Count update:
  - +1 on push only; −1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Never exceeds DATA_DEPTH and never underflows.
- FALL_THROUGH = 0:
  - valid_o = ~empty; data_o = mem[rptr].
  - A word pushed in cycle N is visible at earliest in cycle N+1.
- FALL_THROUGH = 1, when empty:
  - valid_o = valid_i; data_o = data_i.
  - If grant_i is also high, the word passes through: not stored, count unchanged.
  - Otherwise it is stored as normal.
  - When not empty, behaviour is identical to FALL_THROUGH = 0.
- Flags: usage_o = count. Flags are decoded combinationally from count, so they change the cycle after a push or pop.
- clear_i:
  - Has priority over push and pop in the same cycle.
  - Next cycle: pointers = 0, count = 0.
  - Storage contents are untouched.
  - grant_o and valid_o during the clear cycle follow the pre-clear state, but nothing is committed.
- DATA_DEPTH = 1: single entry; pointers are held at 0; toggles between full and empty.
- Parameter checks (simulation only): DATA_DEPTH ≥ 1, DATA_WIDTH ≥ 1, AF_THRESH ≤ DATA_DEPTH, AE_THRESH ≤ DATA_DEPTH. Each violation reports an error.

Optional Feature:
Macro FIFO_CLK_GATE_EN.
- Defined:
  - Storage is clocked by cluster_clock_gating.
  - en_i = push, test_en_i = test_mode_i.
  - The storage write needs no enable beyond the pointer decode.
- Undefined:
  - Storage is clocked by clk with explicit write enable = push.
  - test_mode_i is unused.
- Functional behaviour at ports is identical in both builds.

Decomposition:
- Package fifo_pkg:
  - function fifo_cnt_width(depth) returning $clog2(depth+1).
  - function fifo_ptr_width(depth) returning max(1,$clog2(depth)).
  - Wrap-increment function used for both pointers.
- One sub-module: fifo_ptr_ctrl. Holds pointers, count, full/empty and flags, with push/pop/clear inputs. The top level holds storage, the bypass mux and the clock gate.

Test Plan:
- DATA_DEPTH = 5, FALL_THROUGH = 0, push 0x11..0x55 with grant_i = 0 → grant_o drops after 5th push; usage_o = 5; almost_full_o = 1.
- Then push 0x66 and pop 0x11 together while full → 0x66 refused; usage_o = 4.
- Wrap check: continue streaming 20 words with grant_i = 1 and valid_i = 1 → output order 0x11.. preserved; wptr wraps 4 → 0; usage_o constant.
- FALL_THROUGH = 1, empty, valid_i = 1, data_i = 0xAB, grant_i = 1 → same cycle valid_o = 1, data_o = 0xAB; usage_o stays 0.
- Fill to 3, assert clear_i with valid_i = 1 and grant_i = 1 → next cycle usage_o = 0, valid_o = 0, grant_o = 1; pushed word not retained.
- Assert rst_n low mid-stream with usage_o = 3 → outputs immediately (asynchronously) at reset values: valid_o = 0, usage_o = 0, almost_empty_o = 1. Run with and without FIFO_CLK_GATE_EN; traces must be identical.

Source files
------------

// File: rtl/generic_fifo_flex_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for generic_fifo_flex: counter/pointer width calculation,
// the wrap-around pointer increment and the packed status bundle passed from
// the pointer controller to the top level.
// -----------------------------------------------------------------------------
package fifo_pkg;

  // Status decoded from the entry count.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Bits needed to hold any count in 0..depth.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

  // Bits needed to address depth entries; at least one so depth 1 still has a port.
  function automatic int fifo_ptr_width(input int depth);
    if (depth <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(depth);
    end
  endfunction

  // Pointer increment that wraps depth-1 -> 0, so non power-of-two depths work.
  function automatic int fifo_wrap_inc(input int ptr, input int depth);
    if (ptr >= depth - 32'sd1) begin
      return 32'sd0;
    end else begin
      return ptr + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/cluster_clock_gating.sv
// -----------------------------------------------------------------------------
// cluster_clock_gating
// Latch-based clock gate: the enable is captured while clk_i is low so clk_o
// never glitches. test_en_i forces the gate open for scan.
// Ports: clk_i (clock in), en_i (functional enable), test_en_i (scan bypass),
//        clk_o (gated clock).
// -----------------------------------------------------------------------------
module cluster_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic r_en;

  // Transparent-low enable latch.
  always_latch begin
    if (!clk_i) begin
      r_en <= en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & r_en;

endmodule

// File: rtl/generic_fifo_flex_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
// Read/write pointers, entry count and decoded status flags for
// generic_fifo_flex. The caller presents the already-qualified push/pop
// (i.e. a fall-through bypass must not reach here as push/pop).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_push        commit one write this cycle
//   i_pop         commit one read this cycle
//   i_clear       synchronous flush, dominates push/pop
//   o_wptr/o_rptr storage addresses
//   o_count       number of stored entries
//   o_status      full / empty / almost_full / almost_empty
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_DEPTH = 8,
  parameter int AF_THRESH  = DATA_DEPTH - 32'sd1,
  parameter int AE_THRESH  = 32'sd1,
  parameter int PTR_W      = fifo_ptr_width(DATA_DEPTH),
  parameter int CNT_W      = fifo_cnt_width(DATA_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [PTR_W-1:0] o_wptr,
  output logic [PTR_W-1:0] o_rptr,
  output logic [CNT_W-1:0] o_count,
  output fifo_status_t     o_status
);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  // Pointer and count state; clear wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= PTR_W'(fifo_wrap_inc(int'(r_wptr), DATA_DEPTH));
      end else begin
        r_wptr <= r_wptr;
      end
      if (i_pop) begin
        r_rptr <= PTR_W'(fifo_wrap_inc(int'(r_rptr), DATA_DEPTH));
      end else begin
        r_rptr <= r_rptr;
      end
      // push is only offered when not full and pop only when not empty,
      // so the count cannot leave 0..DATA_DEPTH.
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Status flags decoded straight from the registered count.
  always_comb begin
    o_status              = '0;
    o_status.full         = (int'(r_count) == DATA_DEPTH);
    o_status.empty        = (r_count == '0);
    o_status.almost_full  = (int'(r_count) >= AF_THRESH);
    o_status.almost_empty = (int'(r_count) <= AE_THRESH);
  end

  assign o_wptr  = r_wptr;
  assign o_rptr  = r_rptr;
  assign o_count = r_count;

endmodule

// File: rtl/generic_fifo_flex.sv
// -----------------------------------------------------------------------------
// generic_fifo_flex
// Single-clock valid/grant FIFO of any depth >= 1 with optional fall-through,
// fill level and programmable almost-full / almost-empty flags.
// Build option: define FIFO_CLK_GATE_EN to clock the storage through
// cluster_clock_gating (test_mode_i keeps the gate open in scan); otherwise
// storage uses clk with a write enable and test_mode_i is ignored.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear_i          synchronous flush
//   test_mode_i      clock gate scan bypass
//   data_i/valid_i   push side, accepted when valid_i & grant_o
//   grant_o          not full
//   data_o/valid_o   pop side, consumed when valid_o & grant_i
//   grant_i          pop request
//   usage_o          entry count
//   almost_full_o    usage_o >= AF_THRESH
//   almost_empty_o   usage_o <= AE_THRESH
// -----------------------------------------------------------------------------
module generic_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DATA_DEPTH   = 8,
  parameter int FALL_THROUGH = 0,
  parameter int AF_THRESH    = DATA_DEPTH - 32'sd1,
  parameter int AE_THRESH    = 32'sd1,
  localparam int CNT_W       = fifo_cnt_width(DATA_DEPTH),
  localparam int PTR_W       = fifo_ptr_width(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  test_mode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  grant_i,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  // Elaboration-time parameter sanity.
  if (DATA_DEPTH < 32'sd1) begin : g_chk_depth
    $error("generic_fifo_flex: DATA_DEPTH must be >= 1");
  end
  if (DATA_WIDTH < 32'sd1) begin : g_chk_width
    $error("generic_fifo_flex: DATA_WIDTH must be >= 1");
  end
  if (AF_THRESH > DATA_DEPTH) begin : g_chk_af
    $error("generic_fifo_flex: AF_THRESH must be <= DATA_DEPTH");
  end
  if (AE_THRESH > DATA_DEPTH) begin : g_chk_ae
    $error("generic_fifo_flex: AE_THRESH must be <= DATA_DEPTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

  logic [PTR_W-1:0]      w_wptr;
  logic [PTR_W-1:0]      w_rptr;
  logic [CNT_W-1:0]      w_count;
  fifo_status_t          w_status;

  logic                  w_grant;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_push_c;
  logic                  w_pop_c;
  logic                  w_wr_en;

  // Output side: in fall-through mode an empty FIFO presents the input word.
  always_comb begin
    w_grant = ~w_status.full;
    if ((FALL_THROUGH != 32'sd0) && w_status.empty) begin
      w_valid = valid_i;
      w_data  = data_i;
    end else begin
      w_valid = ~w_status.empty;
      w_data  = r_mem[w_rptr];
    end
  end

  // Handshake qualification. A word that is pushed and popped while the FIFO
  // is empty (only possible in fall-through) passes straight through and
  // touches neither storage nor pointers.
  always_comb begin
    w_push   = valid_i & w_grant;
    w_pop    = w_valid & grant_i;
    w_bypass = w_status.empty & w_push & w_pop;
    w_push_c = w_push & ~w_bypass;
    w_pop_c  = w_pop & ~w_bypass;
    w_wr_en  = w_push_c & ~clear_i;
  end

  fifo_ptr_ctrl #(
    .DATA_DEPTH (DATA_DEPTH),
    .AF_THRESH  (AF_THRESH),
    .AE_THRESH  (AE_THRESH),
    .PTR_W      (PTR_W),
    .CNT_W      (CNT_W)
  ) u_ptr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push_c),
    .i_pop    (w_pop_c),
    .i_clear  (clear_i),
    .o_wptr   (w_wptr),
    .o_rptr   (w_rptr),
    .o_count  (w_count),
    .o_status (w_status)
  );

`ifdef FIFO_CLK_GATE_EN
  logic w_mem_clk;

  cluster_clock_gating u_mem_cg (
    .clk_i     (clk),
    .en_i      (w_wr_en),
    .test_en_i (test_mode_i),
    .clk_o     (w_mem_clk)
  );

  // Storage write; the gated clock only ticks on a committed push.
  always_ff @(posedge w_mem_clk) begin
    r_mem[w_wptr] <= data_i;
  end
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = test_mode_i;

  // Storage write on a committed push; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wptr] <= data_i;
    end
  end
`endif

  assign grant_o        = w_grant;
  assign valid_o        = w_valid;
  assign data_o         = w_data;
  assign usage_o        = w_count;
  assign almost_full_o  = w_status.almost_full;
  assign almost_empty_o = w_status.almost_empty;

endmodule

// File: tb/tb_generic_fifo_flex.sv
// Self-checking bench: dut a is DEPTH 5 / FALL_THROUGH 0, dut b is
// DEPTH 5 / FALL_THROUGH 1. Inputs change on the falling edge and outputs
// are sampled 1 time unit later, well clear of the rising edge.
module tb_generic_fifo_flex;

  localparam int DW = 8;
  localparam int DD = 5;
  localparam int CW = 3;
  localparam int AF = DD - 1;
  localparam int AE = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic tm;

  logic          a_clr, a_vi, a_gi, a_go, a_vo, a_af, a_ae;
  logic [DW-1:0] a_di, a_do;
  logic [CW-1:0] a_us;
  logic          b_clr, b_vi, b_gi, b_go, b_vo, b_af, b_ae;
  logic [DW-1:0] b_di, b_do;
  logic [CW-1:0] b_us;

  generic_fifo_flex #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .FALL_THROUGH(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear_i(a_clr), .test_mode_i(tm),
    .data_i(a_di), .valid_i(a_vi), .grant_o(a_go),
    .data_o(a_do), .valid_o(a_vo), .grant_i(a_gi),
    .usage_o(a_us), .almost_full_o(a_af), .almost_empty_o(a_ae));

  generic_fifo_flex #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .FALL_THROUGH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_i(b_clr), .test_mode_i(tm),
    .data_i(b_di), .valid_i(b_vi), .grant_o(b_go),
    .data_o(b_do), .valid_o(b_vo), .grant_i(b_gi),
    .usage_o(b_us), .almost_full_o(b_af), .almost_empty_o(b_ae));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: one queue of stored words per FIFO.
  logic [DW-1:0] mq [2][$];

  task automatic ref_step(input int id, input bit ft, input logic vi, input logic [DW-1:0] di,
                          input logic gi, input logic clr,
                          output logic ev, output logic [DW-1:0] ed, output logic eg, output int eu);
    int n;
    logic pop, push;
    n  = mq[id].size();
    eg = (n < DD);
    eu = n;
    if (n == 0) begin
      ev = ft ? vi : 1'b0;
      ed = di;
    end else begin
      ev = 1'b1;
      ed = mq[id][0];
    end
    pop  = ev & gi;
    push = vi & eg;
    if (clr) begin
      mq[id].delete();
    end else if (!(n == 0 && pop)) begin
      if (pop)  void'(mq[id].pop_front());
      if (push) mq[id].push_back(di);
    end
  endtask

  typedef struct {
    logic vi; logic [DW-1:0] di; logic gi;
    logic eg; logic ev; logic cd; logic [DW-1:0] ed; int eu; logic eaf; logic eae;
  } vec_t;
  vec_t vt [7];

  logic          ev, eg;
  logic [DW-1:0] ed;
  int            eu;

  initial begin
    // Fill to full without popping, then a push against full with a pop.
    vt[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1, 1'b0, 1'b1};
    vt[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 2, 1'b0, 1'b0};
    vt[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 3, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 4, 1'b1, 1'b0};
    vt[5] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 5, 1'b1, 1'b0};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 4, 1'b1, 1'b0};

    tm = 1'b0; rst_n = 1'b0;
    a_clr = 0; a_vi = 0; a_gi = 0; a_di = '0;
    b_clr = 0; b_vi = 0; b_gi = 0; b_di = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_grant", a_go, 1); chk("rst_a_valid", a_vo, 0); chk("rst_a_usage", a_us, 0);
    chk("rst_a_af", a_af, 0);    chk("rst_a_ae", a_ae, 1);
    chk("rst_b_grant", b_go, 1); chk("rst_b_valid", b_vo, 0); chk("rst_b_usage", b_us, 0);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven fill / full sequence on dut a.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a_vi = vt[i].vi; a_di = vt[i].di; a_gi = vt[i].gi;
      #1;
      chk($sformatf("tbl%0d_grant", i), a_go, vt[i].eg);
      chk($sformatf("tbl%0d_valid", i), a_vo, vt[i].ev);
      if (vt[i].cd) chk($sformatf("tbl%0d_data", i), a_do, vt[i].ed);
      chk($sformatf("tbl%0d_usage", i), a_us, vt[i].eu);
      chk($sformatf("tbl%0d_af", i), a_af, vt[i].eaf);
      chk($sformatf("tbl%0d_ae", i), a_ae, vt[i].eae);
    end
    mq[0] = '{8'h22, 8'h33, 8'h44, 8'h55};

    // Streaming through the wrap point: order kept, usage constant.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a_vi = 1'b1; a_gi = 1'b1; a_di = 8'h60 + 8'(k);
      #1;
      chk("wrap_data", a_do, mq[0][0]);
      chk("wrap_usage", a_us, 4);
      void'(mq[0].pop_front());
      mq[0].push_back(a_di);
    end

    // Clear with a simultaneous push and pop.
    @(negedge clk);
    a_clr = 1'b1; a_vi = 1'b1; a_gi = 1'b1; a_di = 8'hEE;
    #1;
    chk("clr_cyc_grant", a_go, 1); chk("clr_cyc_valid", a_vo, 1);
    @(negedge clk);
    a_clr = 1'b0; a_vi = 1'b0; a_gi = 1'b0;
    #1;
    chk("clr_usage", a_us, 0); chk("clr_valid", a_vo, 0);
    chk("clr_grant", a_go, 1); chk("clr_ae", a_ae, 1);
    mq[0].delete();
    @(negedge clk);
    a_vi = 1'b1; a_di = 8'h77;
    @(negedge clk);
    a_vi = 1'b0;
    #1;
    chk("post_clr_data", a_do, 8'h77); chk("post_clr_usage", a_us, 1);

    // Fall-through on dut b.
    @(negedge clk);
    b_vi = 1'b1; b_di = 8'hAB; b_gi = 1'b1;
    #1;
    chk("ft_valid", b_vo, 1); chk("ft_data", b_do, 8'hAB); chk("ft_usage", b_us, 0);
    @(negedge clk);
    b_vi = 1'b1; b_di = 8'hCD; b_gi = 1'b0;
    #1;
    chk("ft_usage2", b_us, 0); chk("ft_valid2", b_vo, 1); chk("ft_data2", b_do, 8'hCD);
    @(negedge clk);
    b_vi = 1'b0; b_gi = 1'b1;
    #1;
    chk("ft_stored_usage", b_us, 1); chk("ft_stored_data", b_do, 8'hCD);
    @(negedge clk);
    b_gi = 1'b0;
    #1;
    chk("ft_drained", b_us, 0); chk("ft_drained_valid", b_vo, 0);

    // Asynchronous reset with three words held.
    @(negedge clk); a_vi = 1'b1; a_di = 8'h78;
    @(negedge clk); a_di = 8'h79;
    @(negedge clk); a_vi = 1'b0;
    #1;
    chk("pre_rst_usage", a_us, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", a_vo, 0); chk("arst_usage", a_us, 0);
    chk("arst_ae", a_ae, 1);    chk("arst_grant", a_go, 1);
    @(negedge clk); rst_n = 1'b1;
    mq[0].delete(); mq[1].delete();

    // Randomized traffic on both FIFOs against the queue model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      a_vi  = ($urandom_range(0, 9) < 7);
      a_gi  = ($urandom_range(0, 9) < ((c < 300) ? 3 : 7));
      a_di  = 8'($urandom);
      a_clr = ($urandom_range(0, 39) == 0);
      b_vi  = ($urandom_range(0, 9) < 6);
      b_gi  = ($urandom_range(0, 9) < ((c < 300) ? 3 : 7));
      b_di  = 8'($urandom);
      b_clr = ($urandom_range(0, 39) == 0);
      #1;
      ref_step(0, 1'b0, a_vi, a_di, a_gi, a_clr, ev, ed, eg, eu);
      chk("rnd_a_grant", a_go, eg); chk("rnd_a_valid", a_vo, ev);
      if (ev) chk("rnd_a_data", a_do, ed);
      chk("rnd_a_usage", a_us, eu);
      chk("rnd_a_af", a_af, (eu >= AF)); chk("rnd_a_ae", a_ae, (eu <= AE));
      ref_step(1, 1'b1, b_vi, b_di, b_gi, b_clr, ev, ed, eg, eu);
      chk("rnd_b_grant", b_go, eg); chk("rnd_b_valid", b_vo, ev);
      if (ev) chk("rnd_b_data", b_do, ed);
      chk("rnd_b_usage", b_us, eu);
      chk("rnd_b_af", b_af, (eu >= AF)); chk("rnd_b_ae", b_ae, (eu <= AE));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
